// File: rtl/proc_datapath.sv
// proc_datapath: 8-bit accumulator datapath with PC, ACC, IR, carry/zero
// flags and a 5-bit-opcode ALU. Control comes from an external decoder.
// Optional build macro DP_OUT_LATCH_EN adds an IO output latch
// (io_out / io_valid) that captures ACC on every write to IO space.
module proc_datapath (
    input  logic       clk,
    input  logic       clr,
    input  logic       rw,
    input  logic [4:0] alu,
    input  logic       muxa,
    input  logic       muxb,
    input  logic       muxc,
    input  logic       en_ir,
    input  logic       en_da,
    input  logic       en_pc,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic [7:0] ir,
    output logic       carry,
    output logic       zero
`ifdef DP_OUT_LATCH_EN
    ,
    output logic [7:0] io_out,
    output logic       io_valid
`endif
);

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_AND   = 5'b00001;
    localparam logic [4:0] OP_PASSA = 5'b00010;
    localparam logic [4:0] OP_PASSB = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b01100;
    localparam logic [4:0] OP_INC   = 5'b10100;

    logic [7:0] pc_r;
    logic [7:0] acc_r;
    logic [7:0] ir_r;
    logic       carry_r;
    logic       zero_r;

    logic [7:0] opa_s;
    logic [7:0] opb_s;
    logic [8:0] alu_wide_s;
    logic [7:0] alu_res_s;
    logic       carry_upd_s;
    logic       carry_nxt_s;
    logic [7:0] addr_s;

    // Operand selection: A from PC or ACC, B from IR immediate nibble or memory
    always_comb begin
        if (muxa) begin
            opa_s = pc_r;
        end else begin
            opa_s = acc_r;
        end
        if (muxb) begin
            opb_s = {4'h0, ir_r[3:0]};
        end else begin
            opb_s = mem_rdata;
        end
    end

    // 9-bit ALU; bit 8 carries the add carry-out or the subtract borrow
    always_comb begin
        carry_upd_s = 1'b0;
        carry_nxt_s = carry_r;
        case (alu)
            OP_ADD: begin
                alu_wide_s  = {1'b0, opa_s} + {1'b0, opb_s};
                carry_upd_s = 1'b1;
                carry_nxt_s = alu_wide_s[8];
            end
            OP_AND: begin
                alu_wide_s  = {1'b0, opa_s & opb_s};
                carry_upd_s = 1'b1;
                carry_nxt_s = 1'b0;
            end
            OP_PASSA: begin
                alu_wide_s = {1'b0, opa_s};
            end
            OP_PASSB: begin
                alu_wide_s = {1'b0, opb_s};
            end
            OP_SUB: begin
                // Borrow shows up in bit 8; carry means "no borrow" (A >= B)
                alu_wide_s  = {1'b0, opa_s} - {1'b0, opb_s};
                carry_upd_s = 1'b1;
                carry_nxt_s = ~alu_wide_s[8];
            end
            OP_INC: begin
                alu_wide_s = {1'b0, opa_s} + 9'd1;
            end
            default: begin
                alu_wide_s = {1'b0, opa_s};
            end
        endcase
        alu_res_s = alu_wide_s[7:0];
    end

    // Address mux: IO page 0xF0-0xFF from the IR nibble, otherwise PC
    always_comb begin
        if (muxc) begin
            addr_s = {4'hF, ir_r[3:0]};
        end else begin
            addr_s = pc_r;
        end
    end

    // Architectural registers: each enabled register takes this cycle's values
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc_r  <= 8'h00;
            acc_r <= 8'h00;
            ir_r  <= 8'h00;
        end else begin
            if (en_ir) begin
                ir_r <= mem_rdata;
            end
            if (en_da) begin
                acc_r <= alu_res_s;
            end
            if (en_pc) begin
                pc_r <= alu_res_s;
            end
        end
    end

    // Flags follow ACC writes only; carry only for add, sub and and
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
        end else if (en_da) begin
            zero_r <= (alu_res_s == 8'h00);
            if (carry_upd_s) begin
                carry_r <= carry_nxt_s;
            end
        end
    end

`ifdef DP_OUT_LATCH_EN
    logic [7:0] io_out_r;
    logic       io_valid_r;

    // IO latch: capture ACC on a write to IO space, flag valid for one cycle
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            io_out_r   <= 8'h00;
            io_valid_r <= 1'b0;
        end else begin
            io_valid_r <= rw & muxc;
            if (rw && muxc) begin
                io_out_r <= acc_r;
            end
        end
    end

    assign io_out   = io_out_r;
    assign io_valid = io_valid_r;
`endif

    assign mem_addr  = addr_s;
    assign mem_wdata = acc_r;
    assign mem_we    = rw;
    assign ir        = ir_r;
    assign carry     = carry_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_proc_datapath.sv
// Self-checking bench for proc_datapath: a directed vector table, hand
// sequences for reset / IO writes, and randomized cycles against a model.
module tb_proc_datapath;

    logic       clk;
    logic       clr;
    logic       rw;
    logic [4:0] alu;
    logic       muxa, muxb, muxc;
    logic       en_ir, en_da, en_pc;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] ir;
    logic       carry, zero;
`ifdef DP_OUT_LATCH_EN
    logic [7:0] io_out;
    logic       io_valid;
`endif

    proc_datapath dut (
        .clk(clk), .clr(clr), .rw(rw), .alu(alu),
        .muxa(muxa), .muxb(muxb), .muxc(muxc),
        .en_ir(en_ir), .en_da(en_da), .en_pc(en_pc),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .ir(ir), .carry(carry), .zero(zero)
`ifdef DP_OUT_LATCH_EN
        , .io_out(io_out), .io_valid(io_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_pc, m_acc, m_ir;
    logic       m_c, m_z;
    logic [7:0] m_io_out;
    logic       m_io_valid;

    typedef struct {
        logic [4:0] alu;
        logic       muxa, muxb, en_ir, en_da, en_pc;
        logic [7:0] rdata;
        logic [7:0] e_acc, e_pc, e_ir;
        logic       e_c, e_z;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_acc = 8'h00; m_ir = 8'h00;
        m_c = 1'b0; m_z = 1'b0;
        m_io_out = 8'h00; m_io_valid = 1'b0;
    endtask

    // One clock cycle: apply controls, check combinational outputs, advance model
    task automatic drive(input logic [4:0] op, input logic ma, input logic mb,
                         input logic mc, input logic w, input logic ei,
                         input logic ed, input logic ep, input logic [7:0] rd);
        int a, b, r;
        logic [7:0] res;
        logic n_c;
        alu = op; muxa = ma; muxb = mb; muxc = mc; rw = w;
        en_ir = ei; en_da = ed; en_pc = ep; mem_rdata = rd;
        #1;
        chk("comb_addr", mem_addr, mc ? (8'hF0 | (m_ir & 8'h0F)) : m_pc);
        chk("comb_we", {7'd0, mem_we}, {7'd0, w});
        chk("comb_wdata", mem_wdata, m_acc);
        a = ma ? int'(m_pc) : int'(m_acc);
        b = mb ? int'(m_ir & 8'h0F) : int'(rd);
        n_c = m_c;
        case (op)
            5'b00000: begin r = a + b; n_c = (r > 255); end
            5'b00001: begin r = a & b; n_c = 1'b0; end
            5'b00011: r = b;
            5'b01100: begin r = a - b; n_c = (a >= b); end
            5'b10100: r = a + 1;
            default:  r = a;
        endcase
        res = 8'(r & 255);
        @(posedge clk);
        m_io_valid = w & mc;
        if (w && mc) m_io_out = m_acc;
        if (ei) m_ir = rd;
        if (ed) begin
            m_acc = res;
            m_z = (res == 8'h00);
            m_c = n_c;
        end
        if (ep) m_pc = res;
        @(negedge clk);
    endtask

    // Park controls and compare registered state (PC seen through mem_addr)
    task automatic check_vals(input string nm, input logic [7:0] e_acc,
                              input logic [7:0] e_pc, input logic [7:0] e_ir,
                              input logic e_c, input logic e_z);
        muxc = 1'b0; rw = 1'b0; en_ir = 1'b0; en_da = 1'b0; en_pc = 1'b0;
        #1;
        chk({nm, "_acc"}, mem_wdata, e_acc);
        chk({nm, "_pc"}, mem_addr, e_pc);
        chk({nm, "_ir"}, ir, e_ir);
        chk({nm, "_c"}, {7'd0, carry}, {7'd0, e_c});
        chk({nm, "_z"}, {7'd0, zero}, {7'd0, e_z});
    endtask

    task automatic check_state(input string nm);
`ifdef DP_OUT_LATCH_EN
        chk({nm, "_iov"}, {7'd0, io_valid}, {7'd0, m_io_valid});
        chk({nm, "_ioo"}, io_out, m_io_out);
`endif
        check_vals(nm, m_acc, m_pc, m_ir, m_c, m_z);
    endtask

    initial begin
        tbl[0]  = '{5'b00011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h43, 8'h00, 8'h00, 8'h43, 1'b0, 1'b0};
        tbl[1]  = '{5'b00011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 8'h00, 8'h07, 8'h43, 1'b0, 1'b0};
        tbl[2]  = '{5'b10100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h08, 8'h43, 1'b0, 1'b0};
        tbl[3]  = '{5'b00011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 8'hF0, 8'h08, 8'h43, 1'b0, 1'b0};
        tbl[4]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 8'h08, 8'h43, 1'b1, 1'b1};
        tbl[5]  = '{5'b00011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 8'h03, 8'h08, 8'h43, 1'b1, 1'b0};
        tbl[6]  = '{5'b01100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 8'hFE, 8'h08, 8'h43, 1'b0, 1'b0};
        tbl[7]  = '{5'b10100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFE, 8'h09, 8'h43, 1'b0, 1'b0};
        tbl[8]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 8'h09, 8'h43, 1'b1, 1'b1};
        tbl[9]  = '{5'b00011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFE, 8'hFE, 8'h09, 8'h43, 1'b1, 1'b0};
        tbl[10] = '{5'b00001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0F, 8'h0E, 8'h09, 8'h43, 1'b0, 1'b0};
        tbl[11] = '{5'b00000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hAA, 8'h11, 8'h09, 8'h43, 1'b0, 1'b0};
        tbl[12] = '{5'b01100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 8'h00, 8'h09, 8'h43, 1'b1, 1'b1};
        tbl[13] = '{5'b00011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 8'h20, 8'h43, 1'b1, 1'b1};
        tbl[14] = '{5'b00111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 8'h20, 8'h20, 8'h43, 1'b1, 1'b0};
        tbl[15] = '{5'b10100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 8'h21, 8'h21, 8'h55, 1'b1, 1'b0};
        tbl[16] = '{5'b00011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h21, 8'h55, 1'b1, 1'b0};
        tbl[17] = '{5'b10100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h21, 8'h55, 1'b1, 1'b1};
        tbl[18] = '{5'b00010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h21, 8'h21, 8'h55, 1'b1, 1'b0};
        tbl[19] = '{5'b01100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h1C, 8'h21, 8'h55, 1'b1, 1'b0};

        // Reset state
        clr = 1'b0; rw = 1'b0; alu = 5'b00000; muxa = 1'b0; muxb = 1'b0; muxc = 1'b0;
        en_ir = 1'b0; en_da = 1'b0; en_pc = 1'b0; mem_rdata = 8'h00;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_state("reset");
        clr = 1'b1;

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].alu, tbl[i].muxa, tbl[i].muxb, 1'b0, 1'b0,
                  tbl[i].en_ir, tbl[i].en_da, tbl[i].en_pc, tbl[i].rdata);
            check_vals($sformatf("vec%0d", i), tbl[i].e_acc, tbl[i].e_pc,
                       tbl[i].e_ir, tbl[i].e_c, tbl[i].e_z);
        end

        // IO write: ACC=A5, IR=E3, then write to IO space
        drive(5'b00011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);
        drive(5'b00011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hE3);
        alu = 5'b00010; muxa = 1'b0; muxb = 1'b0; muxc = 1'b1; rw = 1'b1;
        en_ir = 1'b0; en_da = 1'b0; en_pc = 1'b0;
        #1;
        chk("io_addr", mem_addr, 8'hF3);
        chk("io_we", {7'd0, mem_we}, 8'h01);
        chk("io_wdata", mem_wdata, 8'hA5);
        // Write that also reloads ACC, then a back-to-back write of the new ACC
        drive(5'b00011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C);
`ifdef DP_OUT_LATCH_EN
        chk("io_out1", io_out, 8'hA5);
        chk("io_valid1", {7'd0, io_valid}, 8'h01);
`endif
        drive(5'b00010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef DP_OUT_LATCH_EN
        chk("io_out2", io_out, 8'h3C);
        chk("io_valid2", {7'd0, io_valid}, 8'h01);
`endif
        drive(5'b00010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef DP_OUT_LATCH_EN
        chk("io_valid_drop", {7'd0, io_valid}, 8'h00);
        chk("io_out_hold", io_out, 8'h3C);
`endif
        check_state("io_end");

        // Asynchronous reset mid-cycle with ACC=5A and nonzero PC
        drive(5'b00011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A);
        check_vals("pre_rst", 8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0);
        #2;
        clr = 1'b0;
        #1;
        model_reset();
        check_vals("async_rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        // Load pending while held in reset is discarded
        alu = 5'b00011; muxb = 1'b0; mem_rdata = 8'h77; en_da = 1'b1; en_pc = 1'b1;
        @(posedge clk); @(negedge clk);
        check_vals("rst_hold", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        clr = 1'b1;
        drive(5'b00011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        check_vals("post_rst", 8'h77, 8'h77, 8'h00, 1'b0, 1'b0);

        // Randomized cycles against the reference model
        for (int k = 0; k < 400; k++) begin
            logic [4:0] op;
            int sel;
            sel = $urandom_range(0, 7);
            case (sel)
                0: op = 5'b00000;
                1: op = 5'b00001;
                2: op = 5'b00010;
                3: op = 5'b00011;
                4: op = 5'b01100;
                5: op = 5'b10100;
                default: op = 5'($urandom_range(0, 31));
            endcase
            drive(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            check_state("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
